// File: rtl/sequence_counter_if.sv
// Control/status bundle between the control unit and the sequence counter.
//   start, halt, clr, step : control requests into the counter
//   code                   : current SC value, feeds the 4-to-16 timing decoder
//   running                : S flip-flop
//   instr_done             : one-cycle pulse the cycle after clr is accepted
//   wrap_err               : sticky flag, SC rolled over without clr
interface sequence_counter_if #(
    parameter int unsigned CODE_W = 4
);
    logic              start;
    logic              halt;
    logic              clr;
    logic              step;
    logic [CODE_W-1:0] code;
    logic              running;
    logic              instr_done;
    logic              wrap_err;

    // Control-unit side: issues requests, observes timing state
    modport master (
        output start, halt, clr, step,
        input  code, running, instr_done, wrap_err
    );

    // Counter side
    modport slave (
        input  start, halt, clr, step,
        output code, running, instr_done, wrap_err
    );
endinterface

// File: rtl/sequence_counter.sv
// Timing-state source for the control unit: sequence counter SC plus
// start/stop flip-flop S.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : sequence_counter_if.slave (start/halt/clr/step in;
//            code/running/instr_done/wrap_err out, all registered)
module sequence_counter #(
    parameter int unsigned CODE_W       = 4,
    parameter bit          RUN_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_counter_if.slave    bus
);
    localparam logic [CODE_W-1:0] SC_MAX = {CODE_W{1'b1}};

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_STOP;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_sc;
    logic [CODE_W-1:0] w_sc_nxt;
    logic              r_step_q;
    logic              r_instr_done;
    logic              r_wrap_err;
    logic              w_wrap_nxt;
    logic              w_step_edge;
    logic              w_advance;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RESET_STATE;
            r_sc         <= '0;
            r_step_q     <= 1'b0;
            r_instr_done <= 1'b0;
            r_wrap_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sc         <= w_sc_nxt;
            r_step_q     <= bus.step;
            r_instr_done <= bus.clr;
            r_wrap_err   <= w_wrap_nxt;
        end
    end

    // Next-state logic: S uses the current state, so an advance in the same
    // cycle as halt still happens; step edges only matter while stopped.
    always_comb begin
        w_state_nxt = r_state;
        w_sc_nxt    = r_sc;
        w_wrap_nxt  = r_wrap_err;
        w_step_edge = bus.step & ~r_step_q;
        w_advance   = (r_state == ST_RUN) | w_step_edge;

        if (bus.halt) begin
            w_state_nxt = ST_STOP;
        end else if (bus.start) begin
            w_state_nxt = ST_RUN;
        end

        if (bus.clr) begin
            w_sc_nxt = '0;
        end else if (w_advance) begin
            w_sc_nxt = r_sc + CODE_W'(1);
            // Rollover without an end-of-phase clear means a runaway instruction
            if (r_sc == SC_MAX) begin
                w_wrap_nxt = 1'b1;
            end
        end
    end

    assign bus.code       = r_sc;
    assign bus.running    = (r_state == ST_RUN);
    assign bus.instr_done = r_instr_done;
    assign bus.wrap_err   = r_wrap_err;
endmodule
